// File: rtl/cm_pkg.sv
// cm library shared package: sort sequencer state type and sizing helper.
// Used by cm_sort_seq (optional descending mode: CM_SORT_SEQ_DESC_EN).
package cm_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } t_cm_sort_seq_state;

    // Ceiling log2, at least 1 so single-bit indices stay legal.
    function automatic int sclog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/cm_sort_seq_cell.sv
// One storage slot of cm_sort_seq: compares the incoming word against its
// own contents and loads new / shifted-up / shifted-down slot contents.
module cm_sort_seq_cell #(
    parameter int DWIDTH = 16,
    parameter int IW     = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_desc,
    input  logic              i_take_new,
    input  logic              i_take_below,
    input  logic              i_pop,
    input  logic [DWIDTH-1:0] i_new_data,
    input  logic [IW-1:0]     i_new_idx,
    input  logic              i_below_vld,
    input  logic [DWIDTH-1:0] i_below_data,
    input  logic [IW-1:0]     i_below_idx,
    input  logic              i_above_vld,
    input  logic [DWIDTH-1:0] i_above_data,
    input  logic [IW-1:0]     i_above_idx,
    output logic              o_gt,
    output logic              o_vld,
    output logic [DWIDTH-1:0] o_data,
    output logic [IW-1:0]     o_idx
);

    logic              r_vld;
    logic [DWIDTH-1:0] r_data;
    logic [IW-1:0]     r_idx;

    // Empty slot acts as +/- infinity, so the new word always goes below it.
    // Strict compare keeps equal keys in arrival order.
    assign o_gt = !r_vld
                | (i_desc ? (r_data < i_new_data)
                          : (r_data > i_new_data));

    // Slot update: pop shifts down, insert loads new word or shifts up.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld  <= 1'b0;
            r_data <= '0;
            r_idx  <= '0;
        end else if (i_pop) begin
            r_vld  <= i_above_vld;
            r_data <= i_above_data;
            r_idx  <= i_above_idx;
        end else if (i_take_below) begin
            r_vld  <= i_below_vld;
            r_data <= i_below_data;
            r_idx  <= i_below_idx;
        end else if (i_take_new) begin
            r_vld  <= 1'b1;
            r_data <= i_new_data;
            r_idx  <= i_new_idx;
        end
    end

    assign o_vld  = r_vld;
    assign o_data = r_data;
    assign o_idx  = r_idx;

endmodule

// File: rtl/cm_sort_seq.sv
// Streaming stable insertion sorter with valid/ready on both sides.
// Define CM_SORT_SEQ_DESC_EN to add the i_desc port (descending mode).
module cm_sort_seq
    import cm_pkg::*;
#(
    parameter int  DCNT      = 8,
    parameter int  DWIDTH    = 16,
    localparam int IDX_WIDTH = sclog2(DCNT)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_vld,
    input  logic [DWIDTH-1:0]    i_data,
    input  logic                 i_last,
`ifdef CM_SORT_SEQ_DESC_EN
    input  logic                 i_desc,
`endif
    output logic                 o_rdy,
    output logic                 o_vld,
    output logic [DWIDTH-1:0]    o_data,
    output logic [IDX_WIDTH-1:0] o_idx,
    output logic                 o_last,
    input  logic                 i_rdy
);

    localparam int CW = IDX_WIDTH + 1;

    t_cm_sort_seq_state r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_rdy;
    logic               r_ovld;

    logic [CW-1:0]        w_cnt_inc;
    logic                 w_ins;
    logic                 w_pop;
    logic                 w_last;
    logic                 w_desc;
    logic [DCNT-1:0]      w_gt;
    logic [DCNT-1:0]      w_vld;
    logic [DWIDTH-1:0]    w_data [DCNT];
    logic [IDX_WIDTH-1:0] w_idx  [DCNT];

    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_ins     = (r_state == FILL) & r_rdy & i_vld;
    assign w_pop     = r_ovld & i_rdy;
    assign w_last    = r_ovld & w_vld[0] & ~w_vld[1];

`ifdef CM_SORT_SEQ_DESC_EN
    logic r_desc;

    // Order mode is captured with the first word and held for the batch.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_desc <= 1'b0;
        end else if (w_ins && r_cnt == '0) begin
            r_desc <= i_desc;
        end
    end

    // Slots are all empty on the first accept, so r_desc is safe to use.
    assign w_desc = r_desc;
`else
    assign w_desc = 1'b0;
`endif

    genvar k;
    for (k = 0; k < DCNT; k++) begin : g_cell
        logic                 w_bgt;
        logic                 w_bv;
        logic [DWIDTH-1:0]    w_bd;
        logic [IDX_WIDTH-1:0] w_bi;
        logic                 w_av;
        logic [DWIDTH-1:0]    w_ad;
        logic [IDX_WIDTH-1:0] w_ai;

        if (k == 0) begin : g_bot
            assign w_bgt = 1'b0;
            assign w_bv  = 1'b0;
            assign w_bd  = '0;
            assign w_bi  = '0;
        end else begin : g_mid_b
            assign w_bgt = w_gt[k-1];
            assign w_bv  = w_vld[k-1];
            assign w_bd  = w_data[k-1];
            assign w_bi  = w_idx[k-1];
        end

        if (k == DCNT - 1) begin : g_top
            assign w_av = 1'b0;
            assign w_ad = '0;
            assign w_ai = '0;
        end else begin : g_mid_a
            assign w_av = w_vld[k+1];
            assign w_ad = w_data[k+1];
            assign w_ai = w_idx[k+1];
        end

        cm_sort_seq_cell #(
            .DWIDTH (DWIDTH),
            .IW     (IDX_WIDTH)
        ) u_cell (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .i_desc       (w_desc),
            .i_take_new   (w_ins & w_gt[k] & ~w_bgt),
            .i_take_below (w_ins & w_bgt),
            .i_pop        (w_pop),
            .i_new_data   (i_data),
            .i_new_idx    (r_cnt[IDX_WIDTH-1:0]),
            .i_below_vld  (w_bv),
            .i_below_data (w_bd),
            .i_below_idx  (w_bi),
            .i_above_vld  (w_av),
            .i_above_data (w_ad),
            .i_above_idx  (w_ai),
            .o_gt         (w_gt[k]),
            .o_vld        (w_vld[k]),
            .o_data       (w_data[k]),
            .o_idx        (w_idx[k])
        );
    end

    // Batch FSM: fill until DCNT words or i_last, then drain to empty.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= FILL;
            r_cnt   <= '0;
            r_rdy   <= 1'b1;
            r_ovld  <= 1'b0;
        end else begin
            unique case (r_state)
                FILL: begin
                    if (w_ins) begin
                        r_cnt <= w_cnt_inc;
                        if (i_last || w_cnt_inc == CW'(DCNT)) begin
                            r_state <= DRAIN;
                            r_rdy   <= 1'b0;
                            r_ovld  <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_pop && w_last) begin
                        r_state <= FILL;
                        r_cnt   <= '0;
                        r_rdy   <= 1'b1;
                        r_ovld  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

    assign o_rdy  = r_rdy;
    assign o_vld  = r_ovld;
    assign o_data = r_ovld ? w_data[0] : '0;
    assign o_idx  = r_ovld ? w_idx[0] : '0;
    assign o_last = w_last;

endmodule

// File: tb/tb_cm_sort_seq.sv
// Scoreboard bench for cm_sort_seq (DCNT=4, DWIDTH=16).
// Covers descending mode when CM_SORT_SEQ_DESC_EN is defined.
module tb_cm_sort_seq;

    localparam int DCNT   = 4;
    localparam int DWIDTH = 16;
    localparam int IW     = 2;

    typedef struct packed {
        logic [DWIDTH-1:0] d;
        logic [IW-1:0]     i;
        logic              l;
    } t_exp;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_vld = 1'b0;
    logic [DWIDTH-1:0] i_data = '0;
    logic              i_last = 1'b0;
    logic              i_rdy = 1'b0;
`ifdef CM_SORT_SEQ_DESC_EN
    logic              i_desc = 1'b0;
`endif
    logic              o_rdy;
    logic              o_vld;
    logic [DWIDTH-1:0] o_data;
    logic [IW-1:0]     o_idx;
    logic              o_last;

    t_exp sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 i_clk = ~i_clk;

    cm_sort_seq #(
        .DCNT   (DCNT),
        .DWIDTH (DWIDTH)
    ) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_vld  (i_vld),
        .i_data (i_data),
        .i_last (i_last),
`ifdef CM_SORT_SEQ_DESC_EN
        .i_desc (i_desc),
`endif
        .o_rdy  (o_rdy),
        .o_vld  (o_vld),
        .o_data (o_data),
        .o_idx  (o_idx),
        .o_last (o_last),
        .i_rdy  (i_rdy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stable selection sort reference: earliest index wins ties.
    task automatic model(input logic [DWIDTH-1:0] w[DCNT], input int n,
                         input bit desc);
        bit   used[DCNT];
        int   best;
        t_exp e;
        for (int j = 0; j < DCNT; j++) used[j] = 1'b0;
        for (int o = 0; o < n; o++) begin
            best = -1;
            for (int j = 0; j < n; j++) begin
                if (!used[j]) begin
                    if (best < 0) best = j;
                    else if (desc ? (w[j] > w[best]) : (w[j] < w[best]))
                        best = j;
                end
            end
            used[best] = 1'b1;
            e.d = w[best];
            e.i = IW'(best);
            e.l = (o == n - 1);
            sb.push_back(e);
        end
    endtask

    task automatic load(input logic [DWIDTH-1:0] w[DCNT], input int n,
                        input bit use_last, input bit desc);
        model(w, n, desc);
        for (int j = 0; j < n; j++) begin
            @(negedge i_clk);
            chk("fill_rdy", 32'(o_rdy), 32'd1);
            chk("fill_vld", 32'(o_vld), 32'd0);
            i_vld  = 1'b1;
            i_data = w[j];
            i_last = use_last && (j == n - 1);
`ifdef CM_SORT_SEQ_DESC_EN
            i_desc = (j == 0) ? desc : ~desc;
`endif
        end
        @(negedge i_clk);
        chk("lat_vld", 32'(o_vld), 32'd1);
        chk("lat_rdy", 32'(o_rdy), 32'd0);
        i_vld  = 1'b0;
        i_last = 1'b0;
    endtask

    task automatic drain();
        t_exp e;
        int   c;
        c = 0;
        i_rdy = 1'b1;
        while (sb.size() > 0 && c < 40) begin
            if (o_vld) begin
                e = sb.pop_front();
                chk("out_data", 32'(o_data), 32'(e.d));
                chk("out_idx", 32'(o_idx), 32'(e.i));
                chk("out_last", 32'(o_last), 32'(e.l));
                chk("drain_rdy", 32'(o_rdy), 32'd0);
            end
            c++;
            @(negedge i_clk);
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
        chk("post_rdy", 32'(o_rdy), 32'd1);
        chk("post_vld", 32'(o_vld), 32'd0);
        i_rdy = 1'b0;
        sb.delete();
    endtask

    initial begin
        logic [DWIDTH-1:0] w[DCNT];

        // Reset held two cycles
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_vld", 32'(o_vld), 32'd0);
        chk("rst_rdy", 32'(o_rdy), 32'd1);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_idx", 32'(o_idx), 32'd0);
        chk("rst_last", 32'(o_last), 32'd0);

        // Full batch
        w = '{16'h0030, 16'h0010, 16'h0040, 16'h0020};
        load(w, 4, 1'b0, 1'b0);
        drain();

        // Partial batch closed by i_last
        w = '{16'h0005, 16'h0003, 16'h0000, 16'h0000};
        load(w, 2, 1'b1, 1'b0);
        drain();

        // Single-word batch
        w = '{16'hbeef, 16'h0000, 16'h0000, 16'h0000};
        load(w, 1, 1'b1, 1'b0);
        drain();

        // Stability with redundant i_last on the 4th word
        w = '{16'h0007, 16'h0007, 16'h0001, 16'h0007};
        load(w, 4, 1'b1, 1'b0);
        drain();

        // Unsigned extremes
        w = '{16'hffff, 16'h0000, 16'h8000, 16'h7fff};
        load(w, 4, 1'b0, 1'b0);
        drain();

        // Back-pressure then reset mid-drain
        w = '{16'h0030, 16'h0010, 16'h0040, 16'h0020};
        load(w, 4, 1'b0, 1'b0);
        i_rdy = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("bp_data", 32'(o_data), 32'h0010);
            chk("bp_idx", 32'(o_idx), 32'd1);
            chk("bp_vld", 32'(o_vld), 32'd1);
            chk("bp_rdy", 32'(o_rdy), 32'd0);
            i_vld  = ~i_vld;
            i_data = 16'h0001;
            @(negedge i_clk);
        end
        i_vld = 1'b0;
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("mid_rst_vld", 32'(o_vld), 32'd1 - 32'd1);
        chk("mid_rst_rdy", 32'(o_rdy), 32'd1);
        chk("mid_rst_data", 32'(o_data), 32'd0);
        sb.delete();
        w = '{16'h0009, 16'h0002, 16'h0009, 16'h0004};
        load(w, 4, 1'b0, 1'b0);
        drain();

`ifdef CM_SORT_SEQ_DESC_EN
        // Descending mode, mode only sampled on the first word
        w = '{16'h0030, 16'h0010, 16'h0040, 16'h0020};
        load(w, 4, 1'b0, 1'b1);
        drain();
        w = '{16'h0007, 16'h0007, 16'h0009, 16'h0007};
        load(w, 4, 1'b0, 1'b1);
        drain();
        w = '{16'h0030, 16'h0010, 16'h0040, 16'h0020};
        load(w, 4, 1'b0, 1'b0);
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
